// File: rtl/writeback_arbiter_if.sv
// Writeback arbiter bus: FX and LoadStore request channels plus the
// registered writeback port toward the GPR file.
interface writeback_arbiter_if #(
   parameter int regWidth  = 5,
   parameter int dataWidth = 64
);
   logic                 fxValid_i;
   logic [regWidth-1:0]  fxAddress_i;
   logic [dataWidth-1:0] fxVal_i;
   logic                 fxReady_o;

   logic                 lsValid_i;
   logic [regWidth-1:0]  lsAddress_i;
   logic [dataWidth-1:0] lsVal_i;
   logic                 lsReady_o;

   logic                 wbReady_i;
   logic                 wbEnable_o;
   logic [regWidth-1:0]  wbAddress_o;
   logic [dataWidth-1:0] wbVal_o;
   logic [2:0]           wbUnitCode_o;

   // Arbiter side
   modport slave (
      input  fxValid_i, fxAddress_i, fxVal_i,
      input  lsValid_i, lsAddress_i, lsVal_i,
      input  wbReady_i,
      output fxReady_o, lsReady_o,
      output wbEnable_o, wbAddress_o, wbVal_o, wbUnitCode_o
   );

   // Execution units / register file side
   modport master (
      output fxValid_i, fxAddress_i, fxVal_i,
      output lsValid_i, lsAddress_i, lsVal_i,
      output wbReady_i,
      input  fxReady_o, lsReady_o,
      input  wbEnable_o, wbAddress_o, wbVal_o, wbUnitCode_o
   );
endinterface

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: two per-unit FIFOs (FX, LoadStore) drained round-robin
// into one registered valid/ready writeback port for the GPR file.
module writeback_arbiter #(
   parameter int         regWidth     = 5,
   parameter int         dataWidth    = 64,
   parameter int         DEPTH        = 2,
   parameter logic [2:0] FXUnitCode   = 3'd0,
   parameter logic [2:0] LdStUnitCode = 3'd2
) (
   input  logic               clock_i,
   input  logic               reset_i,
   writeback_arbiter_if.slave wb
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int FX = 0;
   localparam int LS = 1;

   logic [1:0]           src_valid;
   logic [1:0]           src_ready;
   logic [1:0]           src_push;
   logic [1:0]           src_pop;
   logic [1:0]           src_nonempty;
   logic [regWidth-1:0]  src_addr  [2];
   logic [dataWidth-1:0] src_val   [2];
   logic [regWidth-1:0]  head_addr [2];
   logic [dataWidth-1:0] head_val  [2];

   logic                 wb_en_q, wb_en_d;
   logic [regWidth-1:0]  wb_addr_q, wb_addr_d;
   logic [dataWidth-1:0] wb_val_q, wb_val_d;
   logic [2:0]           wb_code_q, wb_code_d;
   logic                 last_ls_q, last_ls_d;   // 1 = last grant went to LS

   logic                 out_free;
   logic                 load;
   logic                 grant_ls;

   assign src_valid     = {wb.lsValid_i, wb.fxValid_i};
   assign src_addr[FX]  = wb.fxAddress_i;
   assign src_addr[LS]  = wb.lsAddress_i;
   assign src_val[FX]   = wb.fxVal_i;
   assign src_val[LS]   = wb.lsVal_i;

   assign wb.fxReady_o    = src_ready[FX];
   assign wb.lsReady_o    = src_ready[LS];
   assign wb.wbEnable_o   = wb_en_q;
   assign wb.wbAddress_o  = wb_addr_q;
   assign wb.wbVal_o      = wb_val_q;
   assign wb.wbUnitCode_o = wb_code_q;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fifo
         logic [regWidth-1:0]  mem_addr_q [DEPTH];
         logic [dataWidth-1:0] mem_val_q  [DEPTH];
         logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
         logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
         logic [CW-1:0]        count_q, count_d;

         // Ready looks only at the registered count, so a full FIFO refuses
         // a push even on the edge where it is popped.
         assign src_ready[gi]    = (count_q != CW'(DEPTH));
         assign src_nonempty[gi] = (count_q != '0);
         assign src_push[gi]     = src_valid[gi] & src_ready[gi];
         assign head_addr[gi]    = mem_addr_q[rd_ptr_q];
         assign head_val[gi]     = mem_val_q[rd_ptr_q];

         // Pointer and occupancy update; pointers wrap modulo DEPTH
         always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            count_d  = count_q;
            if (src_push[gi]) wr_ptr_d = wr_ptr_q + PW'(1);
            if (src_pop[gi])  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({src_push[gi], src_pop[gi]})
               2'b10:   count_d = count_q + CW'(1);
               2'b01:   count_d = count_q - CW'(1);
               default: count_d = count_q;
            endcase
         end

         // FIFO control registers; reset empties the FIFO
         always_ff @(posedge clock_i or negedge reset_i) begin
            if (!reset_i) begin
               wr_ptr_q <= '0;
               rd_ptr_q <= '0;
               count_q  <= '0;
            end else begin
               wr_ptr_q <= wr_ptr_d;
               rd_ptr_q <= rd_ptr_d;
               count_q  <= count_d;
            end
         end

         // Entry storage; contents are meaningless until counted, so no reset
         always_ff @(posedge clock_i) begin
            if (src_push[gi]) begin
               mem_addr_q[wr_ptr_q] <= src_addr[gi];
               mem_val_q[wr_ptr_q]  <= src_val[gi];
            end
         end
      end
   endgenerate

   // Round-robin pick on registered counts; at most one pop per cycle
   always_comb begin
      out_free = !wb_en_q || wb.wbReady_i;
      if (&src_nonempty) grant_ls = !last_ls_q;
      else               grant_ls = src_nonempty[LS];
      load        = out_free && (|src_nonempty);
      src_pop     = '0;
      src_pop[FX] = load && !grant_ls;
      src_pop[LS] = load && grant_ls;
   end

   // Output register next state: load winner's head, or go idle when empty
   always_comb begin
      wb_en_d   = wb_en_q;
      wb_addr_d = wb_addr_q;
      wb_val_d  = wb_val_q;
      wb_code_d = wb_code_q;
      last_ls_d = last_ls_q;
      if (out_free) wb_en_d = |src_nonempty;
      if (load) begin
         wb_addr_d = grant_ls ? head_addr[LS] : head_addr[FX];
         wb_val_d  = grant_ls ? head_val[LS]  : head_val[FX];
         wb_code_d = grant_ls ? LdStUnitCode  : FXUnitCode;
         last_ls_d = grant_ls;
      end
   end

   // Output and round-robin state; reset favours FX on the first tie
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         wb_en_q   <= 1'b0;
         wb_addr_q <= '0;
         wb_val_q  <= '0;
         wb_code_q <= 3'd0;
         last_ls_q <= 1'b1;
      end else begin
         wb_en_q   <= wb_en_d;
         wb_addr_q <= wb_addr_d;
         wb_val_q  <= wb_val_d;
         wb_code_q <= wb_code_d;
         last_ls_q <= last_ls_d;
      end
   end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: latency, alternation, backpressure,
// full-FIFO push refusal, async reset and LS streaming.
module tb_writeback_arbiter;
   localparam int RW = 5;
   localparam int DW = 64;

   typedef logic [RW+DW-1:0] ent_t;

   logic clock_i = 1'b0;
   logic reset_i = 1'b0;
   int   n_cmp   = 0;
   int   n_err   = 0;

   always #5 clock_i = ~clock_i;

   writeback_arbiter_if #(.regWidth(RW), .dataWidth(DW)) bus ();

   writeback_arbiter #(
      .regWidth(RW), .dataWidth(DW), .DEPTH(2),
      .FXUnitCode(3'd0), .LdStUnitCode(3'd2)
   ) dut (
      .clock_i(clock_i),
      .reset_i(reset_i),
      .wb(bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end else begin
         $display("  ok %s = 0x%0h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clock_i);
      #1;
   endtask

   task automatic set_fx(input logic v, input logic [RW-1:0] a, input logic [DW-1:0] d);
      bus.fxValid_i   = v;
      bus.fxAddress_i = a;
      bus.fxVal_i     = d;
   endtask

   task automatic set_ls(input logic v, input logic [RW-1:0] a, input logic [DW-1:0] d);
      bus.lsValid_i   = v;
      bus.lsAddress_i = a;
      bus.lsVal_i     = d;
   endtask

   task automatic chk_wb(input string tag, input logic [RW-1:0] a, input logic [DW-1:0] d,
                         input logic [2:0] c);
      chk({tag, "_en"},   64'(bus.wbEnable_o),   64'd1);
      chk({tag, "_addr"}, 64'(bus.wbAddress_o),  64'(a));
      chk({tag, "_val"},  bus.wbVal_o,           d);
      chk({tag, "_code"}, 64'(bus.wbUnitCode_o), 64'(c));
   endtask

   task automatic reset_dut();
      reset_i = 1'b0;
      set_fx(1'b0, '0, '0);
      set_ls(1'b0, '0, '0);
      bus.wbReady_i = 1'b1;
      tick();
      reset_i = 1'b1;
   endtask

   // Leaves A in the output register (held by wbReady_i=0) and B, C in the FX FIFO
   task automatic setup_full();
      reset_dut();
      bus.wbReady_i = 1'b0;
      set_fx(1'b1, 5'd1, 64'hA1);
      tick();
      chk("setup_idle_en", 64'(bus.wbEnable_o), 64'd0);
      set_fx(1'b1, 5'd2, 64'hB2);
      tick();
      chk_wb("setup_A", 5'd1, 64'hA1, 3'd0);
      set_fx(1'b1, 5'd3, 64'hC3);
      tick();
      set_fx(1'b0, '0, '0);
   endtask

   initial begin
      ent_t fx_q[$];
      ent_t ls_q[$];
      int   fx_sent;
      int   ls_sent;
      int   outs;

      // ---- 1: reset state and single FX request latency ----
      reset_dut();
      chk("t1_rst_en",    64'(bus.wbEnable_o),   64'd0);
      chk("t1_rst_addr",  64'(bus.wbAddress_o),  64'd0);
      chk("t1_rst_val",   bus.wbVal_o,           64'd0);
      chk("t1_rst_code",  64'(bus.wbUnitCode_o), 64'd0);
      chk("t1_rst_fxrdy", 64'(bus.fxReady_o),    64'd1);
      chk("t1_rst_lsrdy", 64'(bus.lsReady_o),    64'd1);
      set_fx(1'b1, 5'd3, 64'h11);
      tick();
      chk("t1_no_bypass", 64'(bus.wbEnable_o), 64'd0);
      set_fx(1'b0, '0, '0);
      tick();
      chk_wb("t1_out", 5'd3, 64'h11, 3'd0);
      tick();
      chk("t1_idle", 64'(bus.wbEnable_o), 64'd0);

      // ---- 2: both units push every cycle, grants alternate FX first ----
      reset_dut();
      fx_sent = 0;
      ls_sent = 0;
      outs    = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         logic acc_fx, acc_ls, is_ls;
         ent_t e;
         if (cyc < 12) begin
            set_fx(1'b1, 5'(fx_sent), 64'h100 + 64'(fx_sent));
            set_ls(1'b1, 5'(16 + ls_sent), 64'h200 + 64'(ls_sent));
         end else begin
            set_fx(1'b0, '0, '0);
            set_ls(1'b0, '0, '0);
         end
         acc_fx = bus.fxValid_i && bus.fxReady_o;
         acc_ls = bus.lsValid_i && bus.lsReady_o;
         tick();
         if (acc_fx) begin
            fx_q.push_back({bus.fxAddress_i, bus.fxVal_i});
            fx_sent++;
         end
         if (acc_ls) begin
            ls_q.push_back({bus.lsAddress_i, bus.lsVal_i});
            ls_sent++;
         end
         if (bus.wbEnable_o) begin
            if (outs < 10) begin
               is_ls = outs[0];
               chk($sformatf("t2_code%0d", outs), 64'(bus.wbUnitCode_o), is_ls ? 64'd2 : 64'd0);
            end else begin
               is_ls = (bus.wbUnitCode_o == 3'd2);
            end
            if (is_ls ? (ls_q.size() == 0) : (fx_q.size() == 0)) begin
               chk($sformatf("t2_extra%0d", outs), 64'd1, 64'd0);
            end else begin
               e = is_ls ? ls_q.pop_front() : fx_q.pop_front();
               chk($sformatf("t2_entry%0d", outs), 64'(bus.wbVal_o), 64'(e[DW-1:0]));
               chk($sformatf("t2_addr%0d", outs), 64'(bus.wbAddress_o), 64'(e[RW+DW-1:DW]));
            end
            outs++;
         end
      end
      chk("t2_fx_left", 64'(fx_q.size()), 64'd0);
      chk("t2_ls_left", 64'(ls_q.size()), 64'd0);
      chk("t2_fx_flow", 64'(fx_sent >= 5), 64'd1);
      chk("t2_ls_flow", 64'(ls_sent >= 5), 64'd1);

      // ---- 3: backpressure holds outputs; push while full is dropped ----
      setup_full();
      chk("t3_full_rdy", 64'(bus.fxReady_o), 64'd0);
      set_fx(1'b1, 5'd4, 64'hD4);
      tick();
      set_fx(1'b0, '0, '0);
      chk_wb("t3_hold0", 5'd1, 64'hA1, 3'd0);
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk($sformatf("t3_hold%0d_val", i), bus.wbVal_o, 64'hA1);
         chk($sformatf("t3_hold%0d_en", i), 64'(bus.wbEnable_o), 64'd1);
      end
      bus.wbReady_i = 1'b1;
      tick();
      chk_wb("t3_B", 5'd2, 64'hB2, 3'd0);
      chk("t3_rdy_back", 64'(bus.fxReady_o), 64'd1);
      tick();
      chk_wb("t3_C", 5'd3, 64'hC3, 3'd0);
      tick();
      chk("t3_no_D", 64'(bus.wbEnable_o), 64'd0);

      // ---- 4: full FIFO refuses push on pop edge; pointers wrap ----
      setup_full();
      set_fx(1'b1, 5'd4, 64'hD4);
      bus.wbReady_i = 1'b1;
      chk("t4_full_rdy", 64'(bus.fxReady_o), 64'd0);
      tick();
      chk_wb("t4_B", 5'd2, 64'hB2, 3'd0);
      chk("t4_rdy_after_pop", 64'(bus.fxReady_o), 64'd1);
      tick();
      chk_wb("t4_C", 5'd3, 64'hC3, 3'd0);
      set_fx(1'b1, 5'd5, 64'hE5);
      tick();
      chk_wb("t4_D", 5'd4, 64'hD4, 3'd0);
      set_fx(1'b1, 5'd6, 64'hF6);
      tick();
      chk_wb("t4_E", 5'd5, 64'hE5, 3'd0);
      set_fx(1'b0, '0, '0);
      tick();
      chk_wb("t4_F", 5'd6, 64'hF6, 3'd0);
      tick();
      chk("t4_drained", 64'(bus.wbEnable_o), 64'd0);

      // ---- 5: async reset mid-cycle with both FIFOs full ----
      reset_dut();
      bus.wbReady_i = 1'b0;
      set_fx(1'b1, 5'd7, 64'h77);
      set_ls(1'b1, 5'd8, 64'h88);
      repeat (3) tick();
      chk("t5_fx_full", 64'(bus.fxReady_o), 64'd0);
      chk("t5_ls_full", 64'(bus.lsReady_o), 64'd0);
      chk("t5_busy",    64'(bus.wbEnable_o), 64'd1);
      #2;
      reset_i = 1'b0;
      #1;
      chk("t5_async_en",   64'(bus.wbEnable_o),   64'd0);
      chk("t5_async_val",  bus.wbVal_o,           64'd0);
      chk("t5_async_addr", 64'(bus.wbAddress_o),  64'd0);
      chk("t5_fx_rdy",     64'(bus.fxReady_o),    64'd1);
      chk("t5_ls_rdy",     64'(bus.lsReady_o),    64'd1);
      set_fx(1'b0, '0, '0);
      set_ls(1'b0, '0, '0);
      bus.wbReady_i = 1'b1;
      #3;
      reset_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("t5_no_stale%0d", i), 64'(bus.wbEnable_o), 64'd0);
      end

      // ---- 6: LS-only stream 0xA..0xF, one output per cycle ----
      reset_dut();
      for (int i = 0; i < 8; i++) begin
         if (i < 6) set_ls(1'b1, 5'(10 + i), 64'hA + 64'(i));
         else       set_ls(1'b0, '0, '0);
         tick();
         if (i >= 1 && i <= 6)
            chk_wb($sformatf("t6_out%0d", i - 1), 5'(10 + i - 1), 64'hA + 64'(i - 1), 3'd2);
         else if (i == 7)
            chk("t6_idle", 64'(bus.wbEnable_o), 64'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
